// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/redirect sequencer for the 5-stage pipeline,
// with memory freeze, halt drain and performance counters.
module pipeline_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_stall,
    input  logic             id_force_jump,
    input  logic             ex_mispredict,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam logic [1:0] RUN = 2'd0, MEM_WAIT = 2'd1, DRAIN = 2'd2, HALTED = 2'd3;

    logic [1:0] state_q, state_d, ret_q, ret_d, eff;
    logic [3:0] drain_q, drain_d;
    logic       freeze, run_c, drn_c, case_a, case_b, case_c, case_d;

    always_comb begin
        // A releasing MEM_WAIT cycle decodes as the state it interrupted
        eff    = (state_q == MEM_WAIT) ? ret_q : state_q;
        freeze = (state_q == MEM_WAIT) ? !mem_ready :
                 ((state_q == RUN || state_q == DRAIN) && mem_req && !mem_ready);
        run_c  = !rst && !freeze && eff == RUN;
        drn_c  = !rst && !freeze && eff == DRAIN;
        case_a = run_c && ex_mispredict;
        case_b = run_c && !ex_mispredict && id_stall;
        case_c = run_c && !ex_mispredict && !id_stall && id_force_jump;
        case_d = run_c && !ex_mispredict && !id_stall && !id_force_jump && halt_req;
        pc_en       = run_c && !case_b && !case_d;
        pc_sel      = case_a ? 2'd2 : case_c ? 2'd1 : 2'd0;
        if_id_en    = (run_c && !case_b) || (drn_c && !id_stall);
        if_id_flush = rst || case_a || case_c || case_d || drn_c;
        id_ex_en    = run_c || drn_c;
        id_ex_flush = rst || case_a || case_b || (drn_c && (ex_mispredict || id_stall));
        ex_mem_en   = run_c || drn_c;
        mem_wb_en   = run_c || drn_c;
        halted      = !rst && state_q == HALTED;
        state_d = freeze ? MEM_WAIT :
                  eff == RUN ? (case_d ? DRAIN : RUN) :
                  eff == DRAIN ? (drain_q == 4'd0 ? HALTED : DRAIN) : HALTED;
        ret_d   = (freeze && state_q != MEM_WAIT) ? state_q : ret_q;
        drain_d = case_d ? 4'(DRAIN_CYCLES - 1) :
                  (drn_c && drain_q != 4'd0) ? drain_q - 4'd1 : drain_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            ret_q     <= RUN;
            drain_q   <= 4'd0;
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            drain_q   <= drain_d;
            cycle_cnt <= cycle_cnt + CNT_W'(state_q != HALTED);
            stall_cnt <= stall_cnt + CNT_W'(!pc_en && (state_q == RUN || state_q == MEM_WAIT));
            flush_cnt <= flush_cnt + CNT_W'(case_a || case_c);
        end
    end
endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush/redirect sequencer for the 5-stage pipeline. It takes hazard and redirect requests from ID (load-use `stall`, `force_jump`), EX (branch mispredict) and MEM (multi-cycle data-memory handshake). From these it drives per-stage register enables, bubble/flush controls and the PC-source select. It also implements a halt-drain sequence and keeps performance counters.

Parameters:
DRAIN_CYCLES, 3, bubbles injected after a halt request before the core reports halted (1..15)
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_stall  in  1  load-use stall from ID (forward_stalls qualified)
id_force_jump  in  1  J/JAL/JR resolved in ID
ex_mispredict  in  1  EX branch outcome differs from id_branch_taken
mem_req  in  1  MEM stage has a load/store this cycle
mem_ready  in  1  data memory completes access this cycle
halt_req  in  1  halt request (syscall/ebreak) from ID
pc_en  out  1  PC register update enable
pc_sel  out  2  0=pc+4/predict, 1=ID next_pc (jump), 2=EX branch_pc/fallthrough redirect, 3=unused
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX loads bubble
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
halted  out  1  core stopped
cycle_cnt  out  CNT_W  cycles since reset, excluding HALTED
stall_cnt  out  CNT_W  cycles with pc_en=0 in RUN or MEM_WAIT
flush_cnt  out  CNT_W  cycles with if_id_flush=1 caused by a redirect

Behaviour:
- State register: RUN, MEM_WAIT, DRAIN, HALTED. Drain counter is 4 bits. Counters are registered. All control outputs are combinational from state plus current inputs, so the same-cycle stall takes effect.
- Reset (rst=1 at posedge): state=RUN, drain counter=0, all counters=0.
- While rst is high, outputs are forced: pc_en=0, all *_en=0, both flushes=1, pc_sel=0, halted=0.
- Memory freeze: mem_req & !mem_ready in RUN or DRAIN.
  - Forces all enables to 0, both flushes to 0, pc_sel=0.
  - Next state is MEM_WAIT; the previous state (RUN or DRAIN) is remembered.
  - Dominates every other request.
- MEM_WAIT:
  - Outputs are frozen as above.
  - On mem_ready=1 in a cycle, that cycle releases with normal RUN/DRAIN decoding and returns to the remembered state.
  - The drain counter does not decrement while frozen.
- RUN priority, highest first:
  - (a) ex_mispredict: pc_en=1, pc_sel=2, if_id_flush=1, id_ex_flush=1, other enables 1. id_stall, id_force_jump and halt_req are ignored this cycle.
  - (b) id_stall: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1. id_force_jump and halt_req are ignored; ID will re-present them.
  - (c) id_force_jump: pc_en=1, pc_sel=1, if_id_flush=1, all enables 1.
  - (d) halt_req: pc_en=0, if_id_flush=1, other enables 1. Load drain counter with DRAIN_CYCLES−1 and go to DRAIN.
  - (e) otherwise: all enables 1, no flush, pc_sel=0.
- Simultaneous id_force_jump & halt_req: the jump wins; halt_req is re-presented.
- DRAIN:
  - pc_en=0, if_id_flush=1, other enables 1.
  - ex_mispredict only asserts id_ex_flush=1; the PC is not redirected.
  - id_stall still forces if_id_en=0 and id_ex_flush=1.
  - The counter decrements each non-frozen cycle. When it reaches 0 in a non-frozen cycle, go to HALTED next.
- HALTED: all enables 0, flushes 0, halted=1. Exit only via rst. Requests are ignored.
- Counter increments:
  - cycle_cnt increments each cycle not in HALTED and not in reset.
  - stall_cnt increments when pc_en=0 in RUN or MEM_WAIT.
  - flush_cnt increments on cases (a) and (c).
  - All counters wrap modulo 2^CNT_W.

Test Plan:
- Reset then 10 idle cycles → pc_en=1, all enables=1, no flush, pc_sel=0, cycle_cnt=10, stall_cnt=0.
- id_stall=1 for 2 cycles → 2 cycles of pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; stall_cnt=2.
- ex_mispredict=1 with id_stall=1 and id_force_jump=1 in the same cycle → pc_sel=2, both flushes=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then mem_ready=1 → 3 cycles with all enables=0 and no flushes; the 4th cycle is a normal RUN cycle; stall_cnt=3.
- halt_req with DRAIN_CYCLES=3 and a 2-cycle memory wait injected during drain → halted rises after 3 non-frozen drain cycles plus the 2 frozen cycles; cycle_cnt then stops.
- rst asserted mid-DRAIN → next cycle state=RUN, counters=0, halted=0.
